// File: rtl/event_timestamp_fifo.sv
// event_timestamp_fifo: timestamps external event edges against a tick counter and queues them for CPU readout
module event_timestamp_fifo #(
    parameter int DEPTH_LOG2  = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        tick,
    input  logic        event_in,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        irq
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;
    logic                   push_req;
    logic [2:0]             ctrl;
    logic [31:0]            tick_count;
    logic [15:0]            shadow;
    logic                   overflow;
    logic [31:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0]  wr_ptr;
    logic [DEPTH_LOG2-1:0]  rd_ptr;
    logic [DEPTH_LOG2:0]    count;
    logic [15:0]            rd_mux;
    logic                   unused;

    wire synced   = sync[SYNC_STAGES-1];
    wire edge_det = ctrl[2] ? (prev & ~synced) : (synced & ~prev);
    wire wr       = chipselect & ~write_n;
    wire rd       = chipselect & write_n;
    wire flush    = wr && address == 3'd1 && writedata[3];
    wire pop_wr   = wr && address == 3'd4;
    wire nonempty = count != '0;
    wire full     = count[DEPTH_LOG2];
    wire do_pop   = pop_wr & nonempty & ~flush;
    wire do_push  = push_req & (~full | do_pop) & ~flush;
    wire ovf_set  = push_req & full & ~do_pop & ~flush;
    wire [31:0] head = nonempty ? mem[rd_ptr] : 32'd0;

    assign irq    = ctrl[1] & (nonempty | overflow);
    assign unused = ^writedata[15:4];

    // Synchroniser chain for the asynchronous event line
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync <= '0;
        else          sync <= {sync[SYNC_STAGES-2:0], event_in};
    end

    // Edge detect on synchronised samples; the request is registered so a push lands one cycle later
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev     <= 1'b0;
            push_req <= 1'b0;
        end else begin
            prev     <= synced;
            push_req <= ctrl[0] & edge_det;
        end
    end

    // Free-running tick counter; flush takes priority over a same-cycle tick
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  tick_count <= '0;
        else if (flush) tick_count <= '0;
        else if (tick)  tick_count <= tick_count + 32'd1;
    end

    // Timestamp storage; contents are only visible through head, which masks empty
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= tick_count;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (DEPTH_LOG2+1)'(do_push) - (DEPTH_LOG2+1)'(do_pop);
        end
    end

    // Control register, sticky overflow and the LIVE_H shadow
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl     <= '0;
            overflow <= 1'b0;
            shadow   <= '0;
        end else begin
            if (wr && address == 3'd1) ctrl <= writedata[2:0];
            if (ovf_set)                                  overflow <= 1'b1;
            else if (flush || (wr && address == 3'd0))    overflow <= 1'b0;
            if (rd && address == 3'd5) shadow <= tick_count[31:16];
        end
    end

    // Read multiplexer
    always_comb begin
        rd_mux = '0;
        case (address)
            3'd0:    rd_mux = {8'(count), 5'd0, full, overflow, nonempty};
            3'd1:    rd_mux = {13'd0, ctrl};
            3'd2:    rd_mux = head[15:0];
            3'd3:    rd_mux = head[31:16];
            3'd5:    rd_mux = tick_count[15:0];
            3'd6:    rd_mux = shadow;
            default: rd_mux = '0;
        endcase
    end

    // Registered read data, one cycle after the access
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) readdata <= '0;
        else          readdata <= rd_mux;
    end
endmodule
